wb_cal_sched: RTL
=================

# wb_cal_sched

Frame-synchronous calibration scheduler for the white-balance corrector. It turns manual calibration requests from software, plus optional periodic auto-requests, into a single-cycle calibration strobe aligned to start-of-frame. It then holds off further calibrations for a fixed number of frames while statistics accumulate. It also shadows the corrector mode so that mode changes take effect only on frame boundaries. It sits between the white-balance CSR block and the corrector's control inputs.

## Interface
- `CAL_FRAMES`, default 2: number of start-of-frame (SOF) pulses after the strobe SOF before calibration is considered done; range 1..255.
- `FRAME_CNT_W`, default 8: width of the auto-period setting and the frame counter.
- `clk_i` input, 1: clock.
- `rst_i` input, 1: asynchronous, active-high reset.
- `sof_i` input, 1: one-cycle start-of-frame pulse from the video path.
- `cal_req_i` input, 1: one-cycle manual calibration request (CSR strobe).
- `mode_i` input, 2: requested corrector mode from the CSR.
- `period_i` input, FRAME_CNT_W: auto-calibration period in frames; 0 disables auto.
- `cal_stb_o` output, 1: one-cycle calibration strobe to the corrector.
- `mode_o` output, 2: frame-aligned mode to the corrector.
- `busy_o` output, 1: high in ARMED and CAL.
- `done_o` output, 1: one-cycle pulse when calibration completes.

## Operation
- States:
  - IDLE: no calibration in progress.
  - ARMED: request accepted, waiting for SOF.
  - CAL: strobe issued, counting frames.
- IDLE → ARMED on an accepted request (`cal_req_i` or an auto-request).
- ARMED → CAL on `sof_i`:
  - `cal_stb_o` pulses.
  - `cal_cnt` is cleared.
- CAL:
  - each `sof_i` increments `cal_cnt`.
  - On the SOF that makes `cal_cnt == CAL_FRAMES`:
    - `done_o` pulses.
    - Next state is ARMED if a request is pending, else IDLE.
- Pending request:
  - `cal_req_i` (or an auto-request) while in ARMED or CAL sets a one-deep pending flag.
  - Further requests are merged into that flag.
  - The flag clears when its request is consumed, i.e. on the transition to ARMED.
- Request and `sof_i` in the same IDLE cycle: the request is accepted and that SOF is not used; the strobe comes on the following SOF.
- The SOF that ends CAL is never reused as a strobe SOF.
- Mode shadow: `mode_o` loads `mode_i` on every `sof_i`, in any state. Between SOFs `mode_o` holds.
- Auto period (see Configuration):
  - `frame_cnt` counts `sof_i` in IDLE only.
  - When the incremented value is ≥ `period_i` and `period_i != 0`, an auto-request is raised the cycle after that SOF, and `frame_cnt` clears.
  - `frame_cnt` clears on any accepted request.
  - `frame_cnt` saturates at all-ones.
  - Lowering `period_i` below the current count triggers on the next SOF.
- Counter widths: `cal_cnt` is 8 bits; `frame_cnt` is FRAME_CNT_W bits. No wrap-around.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE.
  - `cal_stb_o`, `done_o`, `busy_o` = 0.
  - `mode_o` = 0.
  - counters and pending flag = 0.
- Reset mid-operation aborts to IDLE with no `done_o`.
- Request at cycle t (no SOF at t): `busy_o` is high from t+1.
- First SOF at cycle s > t: `cal_stb_o` is high at s+1 only, and `mode_o` is updated at s+1.
- CAL_FRAMES-th subsequent SOF at cycle e: `done_o` is high at e+1. `busy_o` is low at e+1 unless a request is pending.
- `sof_i` at cycle s: `mode_o` reflects `mode_i` sampled at s, from s+1.
- Maximum strobe rate: one per CAL_FRAMES+1 frames.

## Configuration
- `WB_CAL_SCHED_AUTO_EN`:
  - Defined: the `frame_cnt` and auto-request logic are compiled in.
  - Undefined: `period_i` is ignored (port kept, unconnected internally) and only `cal_req_i` starts calibrations.

## Test plan
- Manual basic, CAL_FRAMES=2:
  - Stimulus: `cal_req_i` at cycle 10; SOFs at 20, 120, 220.
  - Required: `busy_o` from 11, `cal_stb_o` at 21, `done_o` at 221, `busy_o` low at 221.
- Coincident request and SOF:
  - Stimulus: `cal_req_i` and `sof_i` at cycle 20; next SOF at 120.
  - Required: no strobe at 21; `cal_stb_o` at 121.
- Pending merge:
  - Stimulus: three `cal_req_i` pulses during CAL.
  - Required: exactly one extra calibration; its strobe is on the SOF after the done SOF.
- Mode shadow:
  - Stimulus: `mode_i` 0→2 mid-frame, SOF 40 cycles later.
  - Required: `mode_o` stays 0 until the cycle after that SOF, then 2.
- Auto period, macro defined, `period_i`=3:
  - Stimulus: idle SOFs.
  - Required: auto strobe on the 4th SOF.
  - With `period_i`=0: no strobes over 10 frames.
  - Macro undefined: no auto strobes regardless of `period_i`.
- Reset mid-CAL:
  - Stimulus: assert `rst_i` between SOFs in CAL.
  - Required: all outputs 0 immediately; no `done_o` after release; a new request runs a normal sequence.

Source files
------------

// File: rtl/wb_cal_sched.sv
// wb_cal_sched: frame-synchronous white-balance calibration scheduler.
// Latency: request -> busy_o next cycle; SOF -> cal_stb_o/mode_o next cycle; final SOF -> done_o next cycle.
// Backpressure: none; requests while busy merge into a one-deep pending flag, extra requests are dropped.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   sof_i             one-cycle start-of-frame pulse
//   cal_req_i         one-cycle manual calibration request
//   mode_i[1:0]       requested corrector mode, shadowed to mode_o on each SOF
//   period_i          auto-calibration period in frames (0 = off)
//   cal_stb_o         one-cycle calibration strobe, aligned to the cycle after an SOF
//   mode_o[1:0]       frame-aligned corrector mode
//   busy_o            high while armed or calibrating
//   done_o            one-cycle pulse when the calibration hold-off ends
//
// Optional feature: define WB_CAL_SCHED_AUTO_EN to compile in periodic auto-requests.
// Without it period_i is ignored and only cal_req_i starts calibrations.

module wb_cal_sched #(
   parameter int CAL_FRAMES  = 2,
   parameter int FRAME_CNT_W = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   sof_i,
   input  logic                   cal_req_i,
   input  logic [1:0]             mode_i,
   input  logic [FRAME_CNT_W-1:0] period_i,
   output logic                   cal_stb_o,
   output logic [1:0]             mode_o,
   output logic                   busy_o,
   output logic                   done_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      CAL   = 2'd2
   } state_t;

   localparam logic [7:0] CAL_CNT_END = 8'(CAL_FRAMES);

   state_t     state_q, state_d;
   logic [7:0] cal_cnt_q, cal_cnt_d;
   logic       pend_q, pend_d;
   logic       stb_d, done_d;
   logic       auto_req;
   logic       req;
   logic       accept;   // a request is being turned into an ARMED state this cycle

   assign req = cal_req_i | auto_req;

   // Next-state / next-output logic.
   always_comb begin
      state_d   = state_q;
      cal_cnt_d = cal_cnt_q;
      pend_d    = pend_q;
      stb_d     = 1'b0;
      done_d    = 1'b0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            // A coincident SOF is deliberately not used: the strobe waits for the next one.
            if (req) begin
               state_d = ARMED;
               accept  = 1'b1;
            end
         end
         ARMED: begin
            if (req) pend_d = 1'b1;
            if (sof_i) begin
               state_d   = CAL;
               stb_d     = 1'b1;
               cal_cnt_d = 8'd0;
            end
         end
         CAL: begin
            if (req) pend_d = 1'b1;
            if (sof_i) begin
               // Count cannot wrap: it reaches CAL_CNT_END (<= 255) and leaves CAL first.
               cal_cnt_d = cal_cnt_q + 8'd1;
               if (cal_cnt_d == CAL_CNT_END) begin
                  done_d = 1'b1;
                  // The ending SOF only closes CAL; a pending request re-arms and
                  // waits for the next SOF, which caps the strobe rate.
                  if (pend_q || req) begin
                     state_d = ARMED;
                     pend_d  = 1'b0;
                     accept  = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cal_cnt_q <= 8'd0;
         pend_q    <= 1'b0;
         cal_stb_o <= 1'b0;
         done_o    <= 1'b0;
         busy_o    <= 1'b0;
         mode_o    <= 2'd0;
      end else begin
         state_q   <= state_d;
         cal_cnt_q <= cal_cnt_d;
         pend_q    <= pend_d;
         cal_stb_o <= stb_d;
         done_o    <= done_d;
         busy_o    <= (state_d != IDLE);
         if (sof_i) mode_o <= mode_i;
      end
   end

`ifdef WB_CAL_SCHED_AUTO_EN
   logic [FRAME_CNT_W-1:0] frame_cnt_q;
   logic [FRAME_CNT_W-1:0] frame_inc;
   logic                   auto_req_q;

   // Saturating increment of the idle-frame counter.
   always_comb begin
      frame_inc = frame_cnt_q;
      if (frame_cnt_q != {FRAME_CNT_W{1'b1}})
         frame_inc = frame_cnt_q + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
   end

   assign auto_req = auto_req_q;

   // The >= compare makes a lowered period fire on the next idle SOF.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         frame_cnt_q <= '0;
         auto_req_q  <= 1'b0;
      end else begin
         auto_req_q <= 1'b0;
         if (accept) begin
            frame_cnt_q <= '0;
         end else if (state_q == IDLE && sof_i) begin
            if (period_i != '0 && frame_inc >= period_i) begin
               auto_req_q  <= 1'b1;
               frame_cnt_q <= '0;
            end else begin
               frame_cnt_q <= frame_inc;
            end
         end
      end
   end
`else
   logic unused_period;

   assign auto_req      = 1'b0;
   assign unused_period = ^period_i;
`endif

endmodule
